// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, redirect, instruction-memory and IF/ID signals.
// The slave modport is the fetch stage; the master modport is the surrounding pipeline.
interface if_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             Branch_Taken;
  logic [31:0]      Branch_Target;
  logic             Jump;
  logic [31:0]      Jump_Target;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      IF_ID_Instr;
  logic [31:0]      IF_ID_PC4;
  logic             IF_ID_Valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output PC_Write, IF_ID_Write, Branch_Taken, Branch_Target, Jump, Jump_Target, imem_rdata,
    input  imem_addr, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  PC_Write, IF_ID_Write, Branch_Taken, Branch_Target, Jump, Jump_Target, imem_rdata,
    output imem_addr, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register, load-use stall support,
// branch/jump redirect with one-bubble squash, and saturating stall/flush counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input logic       clk,
  input logic       rst_n,
  if_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic             redirect;
  logic [31:0]      redirect_tgt;
  logic [31:0]      pc_plus4;

  // Branch beats jump when both fire: the branch belongs to the older instruction.
  assign redirect     = bus.Branch_Taken | bus.Jump;
  assign redirect_tgt = bus.Branch_Taken ? bus.Branch_Target : bus.Jump_Target;
  assign pc_plus4     = pc_q + 32'd4;

  // Next-state: redirect overrides both write enables, then enables, then hold.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    stall_d = stall_q;
    flush_d = flush_q;

    if (redirect) begin
      pc_d = redirect_tgt;
    end else if (bus.PC_Write) begin
      pc_d = pc_plus4;
    end

    if (redirect) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (bus.IF_ID_Write) begin
      instr_d = bus.imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end

    if (!bus.PC_Write && !redirect && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (redirect && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.IF_ID_Instr = instr_q;
  assign bus.IF_ID_PC4   = pc4_q;
  assign bus.IF_ID_Valid = valid_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule
